spi_fifo_wr_arb: RTL and testbench

//  Shares one FIFO write port between two producers. Port A is the SPI register interface's fifo_wreq/fifo_wdata pulse, which cannot be stalled.

---
 rtl/spi_fifo_wr_arb_if.sv | 33 +++
 rtl/spi_fifo_wr_arb.sv | 94 +++++++++
 tb/tb_spi_fifo_wr_arb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_wr_arb_if.sv
// Bundle of the three write-side ports of spi_fifo_wr_arb: SPI pulse port A,
// the local valid/ready port B and the shared TX FIFO write port.
interface spi_fifo_wr_arb_if #(
  parameter int unsigned DW         = 16,
  parameter int unsigned HOLD_DEPTH = 4,
  parameter int unsigned CNTW       = 8
);
  localparam int unsigned LW = $clog2(HOLD_DEPTH) + 1;

  logic            a_wreq;
  logic [DW-1:0]   a_wdata;
  logic            a_drop;
  logic [CNTW-1:0] a_drop_cnt;
  logic [LW-1:0]   a_level;

  logic            b_valid;
  logic [DW-1:0]   b_data;
  logic            b_ready;

  logic            fifo_wreq;
  logic [DW-1:0]   fifo_wdata;
  logic            fifo_wfull;

  modport slave (
    input  a_wreq, a_wdata, b_valid, b_data, fifo_wfull,
    output a_drop, a_drop_cnt, a_level, b_ready, fifo_wreq, fifo_wdata
  );

  modport master (
    output a_wreq, a_wdata, b_valid, b_data, fifo_wfull,
    input  a_drop, a_drop_cnt, a_level, b_ready, fifo_wreq, fifo_wdata
  );
endinterface

// File: rtl/spi_fifo_wr_arb.sv
// Shares one TX FIFO write port between the unstallable SPI pulse port (A,
// buffered in a small holding queue) and a local valid/ready producer (B).
module spi_fifo_wr_arb #(
  parameter int unsigned DW         = 16,
  parameter int unsigned HOLD_DEPTH = 4,
  parameter int unsigned CNTW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_fifo_wr_arb_if.slave bus
);
  localparam int unsigned PW = $clog2(HOLD_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DW-1:0]   mem [HOLD_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [CNTW-1:0] drop_cnt;
  logic            last_a;

  logic req_a;
  logic req_b;
  logic urgent;
  logic grant_a;
  logic grant_b;
  logic push;
  logic drop;

  // Arbitration: a nearly full A queue pre-empts round-robin.
  always_comb begin
    req_a   = (level != '0);
    req_b   = bus.b_valid;
    urgent  = (level >= LW'(HOLD_DEPTH - 1));
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !bus.fifo_wfull) begin
      if (urgent && req_a) begin
        grant_a = 1'b1;
      end else if (req_a && req_b) begin
        grant_a = !last_a;
        grant_b = last_a;
      end else if (req_a) begin
        grant_a = 1'b1;
      end else if (req_b) begin
        grant_b = 1'b1;
      end
    end
    push = bus.a_wreq && !rst && ((level < LW'(HOLD_DEPTH)) || grant_a);
    drop = bus.a_wreq && !rst && !push;
  end

  assign bus.fifo_wreq  = grant_a | grant_b;
  assign bus.fifo_wdata = grant_a ? mem[rd_ptr] : (grant_b ? bus.b_data : '0);
  assign bus.b_ready    = grant_b;
  assign bus.a_drop     = drop;
  assign bus.a_level    = level;
  assign bus.a_drop_cnt = drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      last_a   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (grant_a) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !grant_a) begin
        level <= level + LW'(1);
      end else if (grant_a && !push) begin
        level <= level - LW'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNTW'(1);
      end
      if (grant_a || grant_b) begin
        last_a <= grant_a;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.a_wdata;
    end
  end
endmodule

// File: tb/tb_spi_fifo_wr_arb.sv
// Directed bench for spi_fifo_wr_arb; a negedge monitor checks every FIFO
// write against per-port expected-word queues.
module tb_spi_fifo_wr_arb;
  localparam int unsigned DW = 16;
  localparam int unsigned HD = 4;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  spi_fifo_wr_arb_if #(.DW(DW), .HOLD_DEPTH(HD), .CNTW(CW)) bus ();

  spi_fifo_wr_arb #(.DW(DW), .HOLD_DEPTH(HD), .CNTW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n B words back to back, holding each until it is consumed.
  task automatic b_send(input int n, input logic [DW-1:0] base);
    bit got;
    for (int i = 0; i < n; i++) begin
      bus.b_valid = 1'b1;
      bus.b_data  = base + DW'(i);
      exp_b.push_back(base + DW'(i));
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        if (bus.b_ready) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL b_timeout: word 0x%0h never consumed", base + DW'(i));
      end
      tick();
    end
    bus.b_valid = 1'b0;
  endtask

  // Scoreboard monitor: B words identified by b_ready, everything else is A.
  always @(negedge clk) begin
    if (bus.fifo_wreq) begin
      check("wreq_while_full", 32'(bus.fifo_wfull), 32'd0);
      if (bus.b_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected: got 0x%0h expected none", bus.fifo_wdata);
        end else begin
          check("b_word", 32'(bus.fifo_wdata), 32'(exp_b.pop_front()));
        end
      end else begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected: got 0x%0h expected none", bus.fifo_wdata);
        end else begin
          check("a_word", 32'(bus.fifo_wdata), 32'(exp_a.pop_front()));
        end
      end
    end else if (bus.b_ready) begin
      check("b_ready_without_wreq", 32'(bus.fifo_wreq), 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.a_wreq     = 1'b0;
    bus.a_wdata    = '0;
    bus.b_valid    = 1'b0;
    bus.b_data     = '0;
    bus.fifo_wfull = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_wreq", 32'(bus.fifo_wreq), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_level", 32'(bus.a_level), 32'd0);
    check("rst_drop_cnt", 32'(bus.a_drop_cnt), 32'd0);

    // 1: single A word, one-cycle latency, no bypass
    bus.a_wreq  = 1'b1;
    bus.a_wdata = 16'h1234;
    exp_a.push_back(16'h1234);
    @(negedge clk);
    check("t1_no_bypass", 32'(bus.fifo_wreq), 32'd0);
    check("t1_no_drop", 32'(bus.a_drop), 32'd0);
    tick();
    bus.a_wreq = 1'b0;
    check("t1_level1", 32'(bus.a_level), 32'd1);
    @(negedge clk);
    check("t1_wreq", 32'(bus.fifo_wreq), 32'd1);
    tick();
    check("t1_level0", 32'(bus.a_level), 32'd0);

    // 2: continuous B plus A every 4 cycles -> A wins each tie
    fork
      b_send(16, 16'hB200);
      begin
        for (int i = 0; i < 4; i++) begin
          bus.a_wreq  = 1'b1;
          bus.a_wdata = 16'hA200 + DW'(i);
          exp_a.push_back(16'hA200 + DW'(i));
          @(negedge clk);
          check("t2_b_before_a", 32'(bus.b_ready), 32'd1);
          tick();
          bus.a_wreq = 1'b0;
          @(negedge clk);
          check("t2_a_grant_ready", 32'(bus.b_ready), 32'd0);
          check("t2_a_grant_wreq", 32'(bus.fifo_wreq), 32'd1);
          tick();
          @(negedge clk);
          check("t2_b_after_a", 32'(bus.b_ready), 32'd1);
          tick();
          @(negedge clk);
          check("t2_b_again", 32'(bus.b_ready), 32'd1);
          tick();
        end
      end
    join
    check("t2_drop_cnt", 32'(bus.a_drop_cnt), 32'd0);
    check("t2_level", 32'(bus.a_level), 32'd0);

    // 3+4: full stall with 6 A pulses, then urgency on release
    bus.fifo_wfull = 1'b1;
    fork
      b_send(1, 16'hB300);
      begin
        for (int i = 0; i < 10; i++) begin
          bus.a_wreq  = (i < 6);
          bus.a_wdata = 16'hA300 + DW'(i);
          if (i < 4) exp_a.push_back(16'hA300 + DW'(i));
          @(negedge clk);
          check("t3_b_ready", 32'(bus.b_ready), 32'd0);
          check("t3_wreq", 32'(bus.fifo_wreq), 32'd0);
          check("t3_drop", 32'(bus.a_drop), (i == 4 || i == 5) ? 32'd1 : 32'd0);
          tick();
        end
        bus.a_wreq = 1'b0;
        check("t3_level", 32'(bus.a_level), 32'd4);
        check("t3_drop_cnt", 32'(bus.a_drop_cnt), 32'd2);
        bus.fifo_wfull = 1'b0;
        @(negedge clk);
        check("t4_l4_a", 32'(bus.b_ready), 32'd0);
        tick();
        check("t4_level3", 32'(bus.a_level), 32'd3);
        @(negedge clk);
        check("t4_urgent_a_wreq", 32'(bus.fifo_wreq), 32'd1);
        check("t4_urgent_a_ready", 32'(bus.b_ready), 32'd0);
        tick();
        @(negedge clk);
        check("t4_b_after_urgent", 32'(bus.b_ready), 32'd1);
        tick();
      end
    join
    repeat (6) tick();
    check("t4_drained", 32'(bus.a_level), 32'd0);

    // 5: push and pop together at a full queue
    bus.fifo_wfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a_wreq  = 1'b1;
      bus.a_wdata = 16'hA500 + DW'(i);
      exp_a.push_back(16'hA500 + DW'(i));
      tick();
    end
    bus.fifo_wfull = 1'b0;
    bus.a_wdata    = 16'hA504;
    exp_a.push_back(16'hA504);
    @(negedge clk);
    check("t5_no_drop", 32'(bus.a_drop), 32'd0);
    check("t5_pop", 32'(bus.fifo_wreq), 32'd1);
    tick();
    bus.a_wreq = 1'b0;
    check("t5_level_kept", 32'(bus.a_level), 32'd4);
    repeat (8) tick();
    check("t5_drained", 32'(bus.a_level), 32'd0);

    // 6: drop counter saturation, then reset with a pending B word
    bus.fifo_wfull = 1'b1;
    bus.a_wreq     = 1'b1;
    bus.a_wdata    = 16'hDEAD;
    repeat (304) tick();
    check("t6_sat", 32'(bus.a_drop_cnt), 32'd255);
    check("t6_full", 32'(bus.a_level), 32'd4);
    bus.b_valid    = 1'b1;
    bus.b_data     = 16'hB600;
    exp_b.push_back(16'hB600);
    bus.fifo_wfull = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    check("t6_rst_wreq", 32'(bus.fifo_wreq), 32'd0);
    check("t6_rst_ready", 32'(bus.b_ready), 32'd0);
    check("t6_rst_drop", 32'(bus.a_drop), 32'd0);
    check("t6_rst_wdata", 32'(bus.fifo_wdata), 32'd0);
    tick();
    rst        = 1'b0;
    bus.a_wreq = 1'b0;
    check("t6_cnt_clr", 32'(bus.a_drop_cnt), 32'd0);
    check("t6_level_clr", 32'(bus.a_level), 32'd0);
    @(negedge clk);
    check("t6_b_after_rst", 32'(bus.b_ready), 32'd1);
    tick();
    bus.b_valid = 1'b0;
    repeat (6) tick();

    check("end_exp_a_empty", 32'(exp_a.size()), 32'd0);
    check("end_exp_b_empty", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
